// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the multiplexer family.
//   sel_e   : 2-bit select encodings used by the fixed-select muxes.
//   rr_next : round-robin successor of a channel index, wrapping at num_ch.
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_TWO   = 2'd2,
    SEL_THREE = 2'd3
  } sel_e;

  // Wraps explicitly at num_ch so non-power-of-2 channel counts never
  // produce an index past the last channel.
  function automatic int rr_next(input int ptr, input int num_ch);
    return (ptr >= num_ch - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req       : per-channel request
//   ptr       : highest-priority channel this cycle
//   grant     : one-hot grant, zero when no request
//   grant_idx : index of the granted channel (0 when no request)
// The search order is ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  int          idx;
  logic [CH_W-1:0] idx_c;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_c     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_W'(idx);
      if (!found && req[idx_c]) begin
        found        = 1'b1;
        grant[idx_c] = 1'b1;
        grant_idx    = idx_c;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: N-channel round-robin multiplexer with one registered output
// stage and valid/ready handshaking on every channel.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   in_valid  : per-channel valid
//   in_data   : channel k at [k*WIDTH +: WIDTH]
//   in_ready  : per-channel ready, one-hot or zero
//   out_valid : output register holds a beat
//   out_data  : registered data
//   out_ch    : channel that produced out_data
//   out_ready : downstream accepts the beat
// Optional build macro MUX_RR_ARB_LOCK_EN adds packet locking:
//   in_last   : per-channel end-of-packet flag
//   out_last  : registered in_last of the held beat
// While a packet is in flight the grant stays on its channel and the
// round-robin pointer only moves when the packet's last beat transfers.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
`ifdef MUX_RR_ARB_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  input  logic                    out_ready
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  logic              can_load;
  logic              xfer;
  logic              advance;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  sel_data;

`ifdef MUX_RR_ARB_LOCK_EN
  logic              lock_q, lock_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic              out_last_q, out_last_d;
  logic [NUM_CH-1:0] lock_mask;
  logic              grant_last;

  // A locked packet masks every other requester; if the owner drops valid
  // nothing is granted rather than letting another channel slip in.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_ch_q] = 1'b1;
    req = lock_q ? (in_valid & lock_mask) : in_valid;
  end

  assign grant_last = in_last[grant_idx];
`else
  assign req = in_valid;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_load = !out_valid_q || out_ready;

  // Gated with reset so no upstream handshake can complete while the
  // output register is held clear.
  assign in_ready = (reset && can_load) ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef MUX_RR_ARB_LOCK_EN
  assign advance = xfer && grant_last;
`else
  assign advance = xfer;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      // Covers the simultaneous drain-and-load case: the new beat simply
      // overwrites the one leaving, so there is no bubble.
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (advance) ptr_d = CH_W'(rr_next(int'(grant_idx), NUM_CH));
  end

`ifdef MUX_RR_ARB_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (xfer) begin
      lock_d     = !grant_last;
      lock_ch_d  = grant_idx;
      out_last_d = grant_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;

  typedef struct {
    logic [3:0]  ch;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  // 4-channel instance
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_ready;

  // 3-channel instance
  logic [2:0]   in_valid_b;
  logic [95:0]  in_data_b;
  logic [2:0]   in_ready_b;
  logic         out_valid_b;
  logic [31:0]  out_data_b;
  logic [1:0]   out_ch_b;
  logic         out_ready_b;

`ifdef MUX_RR_ARB_LOCK_EN
  logic [3:0]   in_last;
  logic         out_last;
  logic [2:0]   in_last_b;
  logic         out_last_b;
`endif

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_rr_arb #(.WIDTH(32), .NUM_CH(4)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
`ifdef MUX_RR_ARB_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  mux_rr_arb #(.WIDTH(32), .NUM_CH(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid_b),
    .in_data   (in_data_b),
    .in_ready  (in_ready_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ch    (out_ch_b),
`ifdef MUX_RR_ARB_LOCK_EN
    .in_last   (in_last_b),
    .out_last  (out_last_b),
`endif
    .out_ready (out_ready_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dv(input int tag, input int k);
    return {16'(tag), 16'(k)};
  endfunction

  task automatic set_data(input int tag);
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = dv(tag, k);
    for (int k = 0; k < 3; k++) in_data_b[k*32 +: 32] = dv(tag, k);
  endtask

  task automatic push_a(input int ch, input int tag, input logic last);
    exp_t e;
    e.ch = 4'(ch); e.data = dv(tag, ch); e.last = last;
    qa.push_back(e);
  endtask

  task automatic push_b(input int ch, input int tag);
    exp_t e;
    e.ch = 4'(ch); e.data = dv(tag, ch); e.last = 1'b1;
    qb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-channel instance: a beat leaves on every edge where
  // out_valid && out_ready, so compare it against the next expectation.
  initial forever begin
    @(negedge clk);
    if (reset && out_valid && out_ready) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected: got ch=%0d data=%0h want=none", out_ch, out_data);
      end else begin
        ea = qa.pop_front();
        chk("a_ch", 32'(out_ch), 32'(ea.ch));
        chk("a_data", out_data, ea.data);
`ifdef MUX_RR_ARB_LOCK_EN
        chk("a_last", 32'(out_last), 32'(ea.last));
`endif
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got ch=%0d data=%0h want=none", out_ch_b, out_data_b);
      end else begin
        eb = qb.pop_front();
        chk("b_ch", 32'(out_ch_b), 32'(eb.ch));
        chk("b_data", out_data_b, eb.data);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    in_valid    = 4'b1111;
    in_valid_b  = 3'b000;
    out_ready   = 1'b1;
    out_ready_b = 1'b1;
    in_data     = '0;
    in_data_b   = '0;
`ifdef MUX_RR_ARB_LOCK_EN
    in_last     = 4'b1111;
    in_last_b   = 3'b111;
`endif
    set_data(1);

    // Reset held with every channel valid
    nxt(); nxt();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    chk("rst_in_ready_b", 32'(in_ready_b), 32'h0);

    nxt();
    reset      = 1'b1;
    in_valid_b = 3'b111;

    // All valid, full throughput: 0,1,2,3,0,1,2,3 and 0,1,2,0,1,2 for 3 ch
    for (int i = 0; i < 8; i++) begin
      push_a(i % 4, 1, 1'b1);
      if (i < 6) push_b(i % 3, 1);
      @(negedge clk);
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      if (i > 0) chk("rr_no_bubble", 32'(out_valid), 32'h1);
      nxt();
      if (i == 5) in_valid_b = 3'b000;
    end
    in_valid = 4'b0000;
    @(negedge clk);
    chk("rr_last_valid", 32'(out_valid), 32'h1);
    nxt();
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_ch_hold", 32'(out_ch), 32'h3);
    chk("drain_data_hold", out_data, dv(1, 3));

    // Stall with ch2 valid, then drain and reload in one cycle
    nxt();
    set_data(2);
    in_valid = 4'b0100;
    push_a(2, 2, 1'b1);
    @(negedge clk);
    chk("st_in_ready", 32'(in_ready), 32'b0100);
    nxt();
    out_ready = 1'b0;
    set_data(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_stall_ready", 32'(in_ready), 32'h0);
      chk("st_stall_valid", 32'(out_valid), 32'h1);
      chk("st_stall_data", out_data, dv(2, 2));
      nxt();
    end
    out_ready = 1'b1;
    push_a(2, 3, 1'b1);
    @(negedge clk);
    chk("st_reload_ready", 32'(in_ready), 32'b0100);
    nxt();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("st_no_bubble", 32'(out_valid), 32'h1);
    chk("st_new_data", out_data, dv(3, 2));
    nxt();

    // ptr is 3: ch0 moves it to 1, then 1001 alternates 3,0,3
    set_data(4);
    in_valid = 4'b0001;
    push_a(0, 4, 1'b1);
    @(negedge clk);
    chk("wr_g0", 32'(in_ready), 32'b0001);
    nxt();
    in_valid = 4'b1001;
    push_a(3, 4, 1'b1);
    @(negedge clk);
    chk("wr_g3", 32'(in_ready), 32'b1000);
    nxt();
    push_a(0, 4, 1'b1);
    @(negedge clk);
    chk("wr_wrap0", 32'(in_ready), 32'b0001);
    nxt();
    push_a(3, 4, 1'b1);
    @(negedge clk);
    chk("wr_g3b", 32'(in_ready), 32'b1000);
    nxt();
    in_valid = 4'b0000;

    // Idle cycles leave ptr at 0, so 1010 grants ch1
    repeat (3) nxt();
    in_valid = 4'b1010;
    push_a(1, 4, 1'b1);
    @(negedge clk);
    chk("idle_fair", 32'(in_ready), 32'b0010);
    nxt();
    in_valid = 4'b0000;
    nxt();

`ifdef MUX_RR_ARB_LOCK_EN
    // ptr is 2: ch0 moves it to 1, then ch1 holds the grant for a packet
    set_data(5);
    in_valid = 4'b0001;
    in_last  = 4'b1111;
    push_a(0, 5, 1'b1);
    @(negedge clk);
    chk("lk_pre", 32'(in_ready), 32'b0001);
    nxt();
    in_valid = 4'b0111;
    in_last  = 4'b0000;
    push_a(1, 5, 1'b0);
    @(negedge clk);
    chk("lk_b0", 32'(in_ready), 32'b0010);
    nxt();
    set_data(6);
    push_a(1, 6, 1'b0);
    @(negedge clk);
    chk("lk_b1", 32'(in_ready), 32'b0010);
    nxt();
    in_valid = 4'b0101;
    @(negedge clk);
    chk("lk_owner_drop", 32'(in_ready), 32'h0);
    nxt();
    set_data(7);
    in_valid = 4'b0111;
    in_last  = 4'b0010;
    push_a(1, 7, 1'b1);
    @(negedge clk);
    chk("lk_b2", 32'(in_ready), 32'b0010);
    nxt();
    in_last = 4'b1111;
    push_a(2, 7, 1'b1);
    @(negedge clk);
    chk("lk_release", 32'(in_ready), 32'b0100);
    nxt();
    in_valid = 4'b0000;
    nxt();
`endif

    repeat (3) nxt();
    chk("qa_empty", 32'(qa.size()), 32'h0);
    chk("qb_empty", 32'(qb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
